// File: rtl/hazard_unit_mdu_if.sv
// Pipeline-side hazard bundle: register addresses, write enables and MDU status in,
// stall/flush/forward controls and the stall performance counter out.
interface hazard_unit_mdu_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned PERF_W = 16
);
  logic [REG_AW-1:0] RsD, RtD, RsE, RtE;
  logic [REG_AW-1:0] WriteRegE, WriteRegM, WriteRegW;
  logic              RegWriteE, RegWriteM, RegWriteW;
  logic              MemtoRegE, MemtoRegM;
  logic              BranchD;
  logic              MduStartE, MduDivE, MduOpD, HiLoReadD;
  logic              PerfClr;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              ForwardAD, ForwardBD;
  logic              StallF, StallD, FlushE;
  logic              MduBusy;
  logic [PERF_W-1:0] StallCount;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD,
           MduStartE, MduDivE, MduOpD, HiLoReadD, PerfClr,
    input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           StallF, StallD, FlushE, MduBusy, StallCount
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD,
           MduStartE, MduDivE, MduOpD, HiLoReadD, PerfClr,
    output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           StallF, StallD, FlushE, MduBusy, StallCount
  );
endinterface

// File: rtl/hazard_unit_mdu.sv
// Hazard/forwarding unit for the 5-stage MIPS pipeline with optional forwarding,
// multi-cycle MDU interlock and a saturating stall-cycle counter.
module hazard_unit_mdu #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned EN_FWD  = 1,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned PERF_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_unit_mdu_if.slave    hz
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_LAT - 1);

  function automatic logic hit(input logic [REG_AW-1:0] src,
                               input logic [REG_AW-1:0] dst,
                               input logic              we);
    return (src != '0) && (src == dst) && we;
  endfunction

  logic rsDE, rtDE, rsDM, rtDM, rsEM, rtEM, rsEW, rtEW;
  logic [1:0] fwdAE, fwdBE;
  logic fwdAD, fwdBD;
  logic lwStall, brStall, rawStall, mduStall, stall;
  logic [CW-1:0] cnt, mduLd;
  logic [PERF_W-1:0] perfCnt;

  assign rsDE = hit(hz.RsD, hz.WriteRegE, hz.RegWriteE);
  assign rtDE = hit(hz.RtD, hz.WriteRegE, hz.RegWriteE);
  assign rsDM = hit(hz.RsD, hz.WriteRegM, hz.RegWriteM);
  assign rtDM = hit(hz.RtD, hz.WriteRegM, hz.RegWriteM);
  assign rsEM = hit(hz.RsE, hz.WriteRegM, hz.RegWriteM);
  assign rtEM = hit(hz.RtE, hz.WriteRegM, hz.RegWriteM);
  assign rsEW = hit(hz.RsE, hz.WriteRegW, hz.RegWriteW);
  assign rtEW = hit(hz.RtE, hz.WriteRegW, hz.RegWriteW);

  // M result is newer than W, so it wins when both stages target the same register
  always_comb begin
    fwdAE = 2'b00;
    fwdBE = 2'b00;
    fwdAD = 1'b0;
    fwdBD = 1'b0;
    if (EN_FWD != 0) begin
      if (rsEM)      fwdAE = 2'b10;
      else if (rsEW) fwdAE = 2'b01;
      if (rtEM)      fwdBE = 2'b10;
      else if (rtEW) fwdBE = 2'b01;
      fwdAD = rsDM;
      fwdBD = rtDM;
    end
  end

  assign lwStall  = hz.MemtoRegE && (rsDE || rtDE);
  assign brStall  = hz.BranchD && (rsDE || rtDE || (hz.MemtoRegM && (rsDM || rtDM)));
  // Register file writes in the first half-cycle, so a W producer never stalls
  assign rawStall = (EN_FWD == 0) && (rsDE || rtDE || rsDM || rtDM);

  assign mduLd    = hz.MduDivE ? DIV_LD : MUL_LD;
  assign mduStall = rst_n && ((cnt != '0) || (hz.MduStartE && (mduLd != '0)))
                    && (hz.MduOpD || hz.HiLoReadD);

  assign stall = lwStall || brStall || rawStall || mduStall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (hz.MduStartE) begin
      cnt <= mduLd;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perfCnt <= '0;
    end else if (hz.PerfClr) begin
      perfCnt <= '0;
    end else if (stall && (perfCnt != '1)) begin
      perfCnt <= perfCnt + 1'b1;
    end
  end

  assign hz.ForwardAE  = fwdAE;
  assign hz.ForwardBE  = fwdBE;
  assign hz.ForwardAD  = fwdAD;
  assign hz.ForwardBD  = fwdBD;
  assign hz.StallF     = stall;
  assign hz.StallD     = stall;
  assign hz.FlushE     = stall;
  assign hz.MduBusy    = (cnt != '0);
  assign hz.StallCount = perfCnt;

endmodule

// File: tb/tb_hazard_unit_mdu.sv
// Scoreboard bench: dutA uses default parameters, dutB is stall-only with MUL_LAT=1,
// DIV_LAT=3 and a 4-bit stall counter.
module tb_hazard_unit_mdu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_unit_mdu_if #(.REG_AW(5), .PERF_W(16)) ifA ();
  hazard_unit_mdu_if #(.REG_AW(5), .PERF_W(4))  ifB ();

  hazard_unit_mdu #(.REG_AW(5), .EN_FWD(1), .MUL_LAT(4), .DIV_LAT(32), .PERF_W(16))
    dutA (.clk(clk), .rst_n(rst_n), .hz(ifA));
  hazard_unit_mdu #(.REG_AW(5), .EN_FWD(0), .MUL_LAT(1), .DIV_LAT(3), .PERF_W(4))
    dutB (.clk(clk), .rst_n(rst_n), .hz(ifB));

  typedef struct {
    int    dut;
    string name;
    int    fAE, fBE, fAD, fBD, stall, busy, cnt;
  } exp_t;

  exp_t expQ[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input int dut, input string nm, input int aE, input int bE,
                     input int aD, input int bD, input int st, input int bz, input int cn);
    exp_t e;
    e.dut = dut; e.name = nm;
    e.fAE = aE; e.fBE = bE; e.fAD = aD; e.fBD = bD;
    e.stall = st; e.busy = bz; e.cnt = cn;
    expQ.push_back(e);
  endtask

  task automatic cmp(input string nm, input string fld, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d at %0t", nm, fld, act, exp, $time);
    end
  endtask

  // Monitor: every cycle, compare the DUT outputs against all queued expectations
  always @(negedge clk) begin
    exp_t e;
    int aE, bE, aD, bD, sF, sD, fE, bz, cn;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      if (e.dut == 0) begin
        aE = int'(ifA.ForwardAE); bE = int'(ifA.ForwardBE);
        aD = int'(ifA.ForwardAD); bD = int'(ifA.ForwardBD);
        sF = int'(ifA.StallF); sD = int'(ifA.StallD); fE = int'(ifA.FlushE);
        bz = int'(ifA.MduBusy); cn = int'(ifA.StallCount);
      end else begin
        aE = int'(ifB.ForwardAE); bE = int'(ifB.ForwardBE);
        aD = int'(ifB.ForwardAD); bD = int'(ifB.ForwardBD);
        sF = int'(ifB.StallF); sD = int'(ifB.StallD); fE = int'(ifB.FlushE);
        bz = int'(ifB.MduBusy); cn = int'(ifB.StallCount);
      end
      cmp(e.name, "ForwardAE", aE, e.fAE);
      cmp(e.name, "ForwardBE", bE, e.fBE);
      cmp(e.name, "ForwardAD", aD, e.fAD);
      cmp(e.name, "ForwardBD", bD, e.fBD);
      cmp(e.name, "StallF", sF, e.stall);
      cmp(e.name, "StallD", sD, e.stall);
      cmp(e.name, "FlushE", fE, e.stall);
      cmp(e.name, "MduBusy", bz, e.busy);
      cmp(e.name, "StallCount", cn, e.cnt);
    end
  end

  task automatic clrA();
    ifA.RsD = '0; ifA.RtD = '0; ifA.RsE = '0; ifA.RtE = '0;
    ifA.WriteRegE = '0; ifA.WriteRegM = '0; ifA.WriteRegW = '0;
    ifA.RegWriteE = 1'b0; ifA.RegWriteM = 1'b0; ifA.RegWriteW = 1'b0;
    ifA.MemtoRegE = 1'b0; ifA.MemtoRegM = 1'b0; ifA.BranchD = 1'b0;
    ifA.MduStartE = 1'b0; ifA.MduDivE = 1'b0; ifA.MduOpD = 1'b0;
    ifA.HiLoReadD = 1'b0; ifA.PerfClr = 1'b0;
  endtask

  task automatic clrB();
    ifB.RsD = '0; ifB.RtD = '0; ifB.RsE = '0; ifB.RtE = '0;
    ifB.WriteRegE = '0; ifB.WriteRegM = '0; ifB.WriteRegW = '0;
    ifB.RegWriteE = 1'b0; ifB.RegWriteM = 1'b0; ifB.RegWriteW = 1'b0;
    ifB.MemtoRegE = 1'b0; ifB.MemtoRegM = 1'b0; ifB.BranchD = 1'b0;
    ifB.MduStartE = 1'b0; ifB.MduDivE = 1'b0; ifB.MduOpD = 1'b0;
    ifB.HiLoReadD = 1'b0; ifB.PerfClr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clrA();
    clrB();
    chk(0, "rstA", 0, 0, 0, 0, 0, 0, 0);
    chk(1, "rstB", 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // E forwarding: M beats W, W alone, zero register never matches
    ifA.RsE = 5'd5; ifA.WriteRegM = 5'd5; ifA.RegWriteM = 1'b1;
    ifA.WriteRegW = 5'd5; ifA.RegWriteW = 1'b1;
    chk(0, "fwdM", 2, 0, 0, 0, 0, 0, 0); tick();
    ifA.RegWriteM = 1'b0;
    chk(0, "fwdW", 1, 0, 0, 0, 0, 0, 0); tick();
    ifA.RsE = 5'd0; ifA.RtE = 5'd5; ifA.RegWriteM = 1'b1;
    chk(0, "fwdZeroRs", 0, 2, 0, 0, 0, 0, 0); tick();

    // load-use
    clrA(); ifA.MemtoRegE = 1'b1; ifA.RegWriteE = 1'b1; ifA.WriteRegE = 5'd8; ifA.RtD = 5'd8;
    chk(0, "lwStall", 0, 0, 0, 0, 1, 0, 0); tick();
    ifA.RtD = 5'd0; ifA.WriteRegE = 5'd0;
    chk(0, "lwZero", 0, 0, 0, 0, 0, 0, 1); tick();

    // branch after load in M, then after ALU op in M
    clrA(); ifA.BranchD = 1'b1; ifA.RsD = 5'd3; ifA.WriteRegM = 5'd3;
    ifA.RegWriteM = 1'b1; ifA.MemtoRegM = 1'b1;
    chk(0, "brLoadM", 0, 0, 1, 0, 1, 0, 1); tick();
    ifA.MemtoRegM = 1'b0;
    chk(0, "brAluM", 0, 0, 1, 0, 0, 0, 2); tick();

    // everything targets r0
    clrA(); ifA.BranchD = 1'b1; ifA.RegWriteE = 1'b1; ifA.MemtoRegE = 1'b1;
    ifA.RegWriteM = 1'b1; ifA.MemtoRegM = 1'b1; ifA.RegWriteW = 1'b1;
    chk(0, "allZero", 0, 0, 0, 0, 0, 0, 2); tick();

    clrA(); ifA.RtD = 5'd7; ifA.RsE = 5'd7; ifA.RtE = 5'd7;
    ifA.WriteRegM = 5'd7; ifA.RegWriteM = 1'b1;
    chk(0, "fwdBoth", 2, 2, 0, 1, 0, 0, 2); tick();

    clrA(); ifA.BranchD = 1'b1; ifA.RsD = 5'd9; ifA.WriteRegE = 5'd9; ifA.RegWriteE = 1'b1;
    chk(0, "brE", 0, 0, 0, 0, 1, 0, 2); tick();

    // divide with mfhi waiting: 32 stall cycles
    clrA(); ifA.MduStartE = 1'b1; ifA.MduDivE = 1'b1; ifA.HiLoReadD = 1'b1;
    chk(0, "divStart", 0, 0, 0, 0, 1, 0, 3); tick();
    ifA.MduStartE = 1'b0; ifA.MduDivE = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      chk(0, "divBusy", 0, 0, 0, 0, 1, 1, 3 + k); tick();
    end
    chk(0, "divDone", 0, 0, 0, 0, 0, 0, 35); tick();

    // multiply followed by another MDU op
    clrA(); ifA.MduStartE = 1'b1; ifA.MduOpD = 1'b1;
    chk(0, "mulStart", 0, 0, 0, 0, 1, 0, 35); tick();
    ifA.MduStartE = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk(0, "mulBusy", 0, 0, 0, 0, 1, 1, 35 + k); tick();
    end
    chk(0, "mulDone", 0, 0, 0, 0, 0, 0, 39); tick();

    clrA(); ifA.PerfClr = 1'b1;
    chk(0, "clrIssue", 0, 0, 0, 0, 0, 0, 39); tick();
    ifA.PerfClr = 1'b0;
    chk(0, "clrDone", 0, 0, 0, 0, 0, 0, 0); tick();

    // reset asserted mid-divide when cnt=10
    clrA(); ifA.MduStartE = 1'b1; ifA.MduDivE = 1'b1; ifA.HiLoReadD = 1'b1;
    chk(0, "div2Start", 0, 0, 0, 0, 1, 0, 0); tick();
    ifA.MduStartE = 1'b0; ifA.MduDivE = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      chk(0, "div2Busy", 0, 0, 0, 0, 1, 1, k); tick();
    end
    rst_n = 1'b0;
    ifA.RsE = 5'd5; ifA.WriteRegM = 5'd5; ifA.RegWriteM = 1'b1;
    chk(0, "rstMidDiv", 2, 0, 0, 0, 0, 0, 0); tick();
    rst_n = 1'b1;
    clrA(); ifA.HiLoReadD = 1'b1;
    chk(0, "rstRelease", 0, 0, 0, 0, 0, 0, 0); tick();
    chk(0, "postRst", 0, 0, 0, 0, 0, 0, 0); tick();

    // stall-only instance: raw stall, saturation, clear
    clrA(); clrB();
    ifB.RsD = 5'd4; ifB.WriteRegM = 5'd4; ifB.RegWriteM = 1'b1;
    ifB.RsE = 5'd4; ifB.RtE = 5'd4; ifB.WriteRegW = 5'd4; ifB.RegWriteW = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      chk(1, "rawSat", 0, 0, 0, 0, 1, 0, (j - 1 > 15) ? 15 : j - 1); tick();
    end
    ifB.PerfClr = 1'b1;
    chk(1, "clrInStall", 0, 0, 0, 0, 1, 0, 15); tick();
    ifB.PerfClr = 1'b0;
    chk(1, "afterClr", 0, 0, 0, 0, 1, 0, 0); tick();

    clrB(); ifB.RsD = 5'd4; ifB.RsE = 5'd4; ifB.WriteRegW = 5'd4; ifB.RegWriteW = 1'b1;
    chk(1, "rawW", 0, 0, 0, 0, 0, 0, 1); tick();
    clrB(); ifB.RtD = 5'd6; ifB.WriteRegE = 5'd6; ifB.RegWriteE = 1'b1;
    chk(1, "rawE", 0, 0, 0, 0, 1, 0, 1); tick();

    // MUL_LAT=1 never stalls; DIV_LAT=3 stalls three cycles
    clrB(); ifB.MduStartE = 1'b1; ifB.MduOpD = 1'b1;
    chk(1, "mul1Start", 0, 0, 0, 0, 0, 0, 2); tick();
    ifB.MduStartE = 1'b0;
    chk(1, "mul1After", 0, 0, 0, 0, 0, 0, 2); tick();
    clrB(); ifB.MduStartE = 1'b1; ifB.MduDivE = 1'b1; ifB.HiLoReadD = 1'b1;
    chk(1, "div3Start", 0, 0, 0, 0, 1, 0, 2); tick();
    ifB.MduStartE = 1'b0; ifB.MduDivE = 1'b0;
    chk(1, "div3Busy1", 0, 0, 0, 0, 1, 1, 3); tick();
    chk(1, "div3Busy2", 0, 0, 0, 0, 1, 1, 4); tick();
    chk(1, "div3Done", 0, 0, 0, 0, 0, 0, 5); tick();

    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
